// File: rtl/uart_tx.sv
// 8N1, LSB-first UART transmitter fed by a small circular byte FIFO.
// Queued bytes are sent as contiguous frames, with no idle gap between them.
module uart_tx #(
    parameter int CLKS_PER_TICK = 652,
    parameter int TICKS_PER_BIT = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    output logic                        uart_rxd_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [1:0]                  fsm_state
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int CLK_W  = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CLK_W-1:0]  CLK_MAX  = CLK_W'(CLKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
    logic [CLK_W-1:0]  clk_cnt;
    logic [TICK_W-1:0] tick_cnt;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic bit_end;
    logic fifo_empty;
    logic push;
    logic pop;
    logic [7:0] head;

    // Handshake: a byte is taken on every rising edge where byte_valid && byte_ready;
    // byte_valid may be held across cycles and byte_in must stay stable until taken.
    assign byte_ready = (count != CW'(FIFO_DEPTH)) && !rst;
    assign push       = byte_valid && byte_ready;
    assign fifo_empty = (count == '0);
    assign bit_end    = (clk_cnt == CLK_MAX) && (tick_cnt == TICK_MAX);
    // The FIFO head is consumed when a frame starts from idle or chains off a stop bit.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign head       = mem[rd_ptr];

    assign busy       = (state != IDLE) || !fifo_empty;
    assign fifo_count = count;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            uart_rxd_out <= 1'b1;
            shift        <= '0;
            bit_idx      <= '0;
            clk_cnt      <= '0;
            tick_cnt     <= '0;
        end else begin
            // Counters idle at zero so every frame starts with a full start bit.
            if (state == IDLE) begin
                clk_cnt  <= '0;
                tick_cnt <= '0;
            end else if (clk_cnt == CLK_MAX) begin
                clk_cnt  <= '0;
                tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TICK_W'(1);
            end else begin
                clk_cnt <= clk_cnt + CLK_W'(1);
            end

            case (state)
                IDLE: begin
                    uart_rxd_out <= 1'b1;
                    if (pop) begin
                        shift        <= head;
                        bit_idx      <= '0;
                        uart_rxd_out <= 1'b0;
                        state        <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        uart_rxd_out <= shift[0];
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            uart_rxd_out <= 1'b1;
                            state        <= STOP;
                        end else begin
                            shift        <= {1'b0, shift[7:1]};
                            bit_idx      <= bit_idx + 3'd1;
                            uart_rxd_out <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift        <= head;
                            bit_idx      <= '0;
                            uart_rxd_out <= 1'b0;
                            state        <= START;
                        end else begin
                            uart_rxd_out <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    uart_rxd_out <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with a 16-cycle bit period: directed pushes, a line monitor
// that decodes every frame against an expected-byte queue, and a final report.
module tb_uart_tx;
    localparam int CPT   = 4;
    localparam int TPB   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = CPT * TPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       uart_rxd_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLKS_PER_TICK(CPT),
        .TICKS_PER_BIT(TPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .uart_rxd_out(uart_rxd_out),
        .busy(busy),
        .fifo_count(fifo_count),
        .fsm_state(fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog sim did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Present a byte, hold valid until accepted; returns the accepting cycle.
    task automatic push_byte(input logic [7:0] b, input int max_wait, output int acc);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        chk_eq("push_ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        acc        = cyc;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input int c0, input int limit, output int elapsed);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_timeout", {31'b0, busy}, 32'd0);
        elapsed = cyc - c0;
    endtask

    // Line monitor: samples every cycle of every bit; a reset aborts the frame.
    initial begin : rx_mon
        logic [7:0] d;
        logic ok;
        logic abort;
        logic v;
        forever begin
            @(negedge clk);
            if (!rst && uart_rxd_out === 1'b0) begin
                ok = 1'b1;
                abort = 1'b0;
                d = 8'h00;
                for (int s = 1; s < BIT; s++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    if (uart_rxd_out !== 1'b0) ok = 1'b0;
                end
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    v = uart_rxd_out;
                    d[k] = v;
                    for (int s = 1; s < BIT; s++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                        if (uart_rxd_out !== v) ok = 1'b0;
                    end
                end
                for (int s = 0; s < BIT; s++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    if (uart_rxd_out !== 1'b1) ok = 1'b0;
                end
                if (!abort) begin
                    rx_count++;
                    chk_eq("frame_shape", {31'b0, ok}, 32'd1);
                    chk_eq("rx_expected_pending", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        chk_eq("rx_byte", {24'b0, d}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int c0;
        int acc;
        int el;
        int lows;

        // reset
        repeat (3) @(negedge clk);
        chk_eq("ready_in_rst", {31'b0, byte_ready}, 32'd0);
        chk_eq("line_in_rst", {31'b0, uart_rxd_out}, 32'd1);
        rst = 1'b0;
        #1;
        chk_eq("ready_after_rst", {31'b0, byte_ready}, 32'd1);
        chk_eq("busy_after_rst", {31'b0, busy}, 32'd0);
        chk_eq("count_after_rst", {29'b0, fifo_count}, 32'd0);
        chk_eq("state_after_rst", {30'b0, fsm_state}, 32'd0);
        @(negedge clk);

        // single byte: pop one edge after push, 10*16 cycle frame
        push_byte(8'h55, 10, c0);
        chk_eq("single_count_after_push", {29'b0, fifo_count}, 32'd1);
        chk_eq("single_line_after_push", {31'b0, uart_rxd_out}, 32'd1);
        @(posedge clk);
        #1;
        chk_eq("single_line_start", {31'b0, uart_rxd_out}, 32'd0);
        chk_eq("single_count_after_pop", {29'b0, fifo_count}, 32'd0);
        chk_eq("single_busy", {31'b0, busy}, 32'd1);
        wait_idle(c0, 400, el);
        chk_eq("single_elapsed", el, 32'd161);
        chk_eq("single_line_idle", {31'b0, uart_rxd_out}, 32'd1);
        repeat (5) @(negedge clk);

        // back-to-back pair, contiguous frames
        push_byte(8'hA5, 10, c0);
        push_byte(8'h3C, 10, acc);
        chk_eq("b2b_second_accept", acc - c0, 32'd1);
        wait_idle(c0, 800, el);
        chk_eq("b2b_elapsed", el, 32'd321);
        repeat (5) @(negedge clk);

        // edge-value bytes
        push_byte(8'h00, 10, c0);
        push_byte(8'hFF, 10, acc);
        push_byte(8'h81, 10, acc);
        wait_idle(c0, 1000, el);
        chk_eq("edge_bytes_elapsed", el, 32'd481);
        repeat (5) @(negedge clk);

        // FIFO full with valid held
        push_byte(8'h11, 10, c0);
        push_byte(8'h22, 10, acc);
        push_byte(8'h33, 10, acc);
        push_byte(8'h44, 10, acc);
        push_byte(8'h66, 10, acc);
        chk_eq("full_accept5", acc - c0, 32'd4);
        chk_eq("full_ready_low", {31'b0, byte_ready}, 32'd0);
        chk_eq("full_count", {29'b0, fifo_count}, 32'd4);
        push_byte(8'h77, 400, acc);
        chk_eq("full_accept6", acc - c0, 32'd162);
        chk_eq("full_count_after6", {29'b0, fifo_count}, 32'd4);
        wait_idle(c0, 2000, el);
        chk_eq("full_elapsed", el, 32'd961);
        repeat (5) @(negedge clk);

        // reset during data bit 3 with two bytes queued
        push_byte(8'h5A, 10, c0);
        push_byte(8'hC3, 10, acc);
        push_byte(8'h0F, 10, acc);
        while (cyc < c0 + 70) @(negedge clk);
        chk_eq("rst_pre_state_data", {30'b0, fsm_state}, 32'd2);
        chk_eq("rst_pre_bit3", {31'b0, uart_rxd_out}, 32'd1);
        chk_eq("rst_pre_count", {29'b0, fifo_count}, 32'd2);
        rst = 1'b1;
        byte_in = 8'hEE;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk_eq("rst_line", {31'b0, uart_rxd_out}, 32'd1);
        chk_eq("rst_count", {29'b0, fifo_count}, 32'd0);
        chk_eq("rst_busy", {31'b0, busy}, 32'd0);
        chk_eq("rst_ready_low", {31'b0, byte_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk_eq("rst_ready_high", {31'b0, byte_ready}, 32'd1);
        chk_eq("rst_valid_ignored", {29'b0, fifo_count}, 32'd0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_rxd_out !== 1'b1) lows++;
        end
        chk_eq("rst_no_more_frames", lows, 32'd0);
        push_byte(8'h96, 10, c0);
        wait_idle(c0, 400, el);
        chk_eq("rst_new_elapsed", el, 32'd161);
        repeat (5) @(negedge clk);

        // 20-byte stream, pointers wrap several times
        push_byte(8'h00, 10, c0);
        for (int i = 1; i < 20; i++) begin
            push_byte(8'(i), 400, acc);
        end
        wait_idle(c0, 5000, el);
        chk_eq("stream_elapsed", el, 32'd3201);
        repeat (5) @(negedge clk);

        chk_eq("rx_total", rx_count, 32'd33);
        chk_eq("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
